// File: rtl/vec_mem_pkg.sv
// Shared constants and types for the unit-stride vector load/store engine.
package vec_mem_pkg;
    localparam int VLEN       = 8;
    localparam int ELEN       = 32;
    localparam int BEAT_W     = 128;
    localparam int ADDR_W     = 32;
    localparam int VREG_W     = VLEN * ELEN;
    localparam int NBEATS     = VREG_W / BEAT_W;
    localparam int EPB        = BEAT_W / ELEN;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int OFF_W      = $clog2(BEAT_BYTES);
    localparam int CNT_W      = $clog2(NBEATS + 1);
    localparam int IDX_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WB, FINISH, ERR} state_e;
endpackage

// File: rtl/vec_beat_buffer.sv
// NBEATS x BEAT_W register: bulk-loaded with store data at accept, or filled
// one lane per returned load beat; always read out at full width.
module vec_beat_buffer
    import vec_mem_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           load_all,
    input  logic [NBEATS-1:0][BEAT_W-1:0]  load_data,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [BEAT_W-1:0]              wr_data,
    output logic [NBEATS-1:0][BEAT_W-1:0]  rd_data
);
    for (genvar g = 0; g < NBEATS; g++) begin : g_lane
        logic [BEAT_W-1:0] lane_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                lane_q <= '0;
            else if (load_all)
                lane_q <= load_data[g];
            else if (wr_en && wr_idx == IDX_W'(g))
                lane_q <= wr_data;
        end

        assign rd_data[g] = lane_q;
    end
endmodule

// File: rtl/vector_mem_unit.sv
// Unit-stride vle32/vse32 engine: splits one vector register into DTIM beats,
// assembles load beats into a single VRF write and pulses done on completion.
module vector_mem_unit
    import vec_mem_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_store,
    input  logic [ADDR_W-1:0]       req_base,
    input  logic [4:0]              req_vreg,
    input  logic [VREG_W-1:0]       req_sdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic                    mem_req_we,
    output logic [BEAT_W-1:0]       mem_req_wdata,
    output logic [BEAT_W/8-1:0]     mem_req_wmask,
    input  logic                    mem_resp_valid,
    input  logic [BEAT_W-1:0]       mem_resp_rdata,
    output logic                    vrf_we,
    output logic [4:0]              vrf_waddr,
    output logic [VREG_W-1:0]       vrf_wdata,
    output logic                    done,
    output logic                    err_misaligned
);
    state_e                         state, state_nx;
    logic [CNT_W-1:0]               issue_cnt, resp_cnt;
    logic                           is_store_q;
    logic [ADDR_W-1:0]              base_q;
    logic [4:0]                     vreg_q;
    logic [NBEATS-1:0][BEAT_W-1:0]  beat_buf;
    logic accept, issuing, issue_fire, last_issue, resp_en, resp_done, misaligned;

    assign accept     = req_valid && req_ready;
    assign issuing    = (state == ISSUE);
    assign issue_fire = issuing && mem_req_ready;
    assign last_issue = (issue_cnt == CNT_W'(NBEATS - 1));
    assign misaligned = (req_base[OFF_W-1:0] != '0);
    // Responses outside an active load (or beyond the last beat) are dropped.
    assign resp_en    = mem_resp_valid && !is_store_q && (state == ISSUE || state == DRAIN)
                        && (resp_cnt != CNT_W'(NBEATS));
    assign resp_done  = (resp_cnt == CNT_W'(NBEATS))
                        || (resp_en && resp_cnt == CNT_W'(NBEATS - 1));

    vec_beat_buffer u_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_all  (accept),
        .load_data (req_sdata),
        .wr_en     (resp_en),
        .wr_idx    (resp_cnt[IDX_W-1:0]),
        .wr_data   (mem_resp_rdata),
        .rd_data   (beat_buf)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = misaligned ? ERR : ISSUE;
            ISSUE:   if (issue_fire && last_issue) state_nx = is_store_q ? FINISH : DRAIN;
            DRAIN:   if (resp_done) state_nx = WB;
            WB:      state_nx = IDLE;
            FINISH:  state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state == IDLE);
        mem_req_valid  = issuing;
        mem_req_we     = issuing && is_store_q;
        mem_req_addr   = issuing ? base_q + (ADDR_W'(issue_cnt) << OFF_W) : '0;
        mem_req_wdata  = mem_req_we ? beat_buf[issue_cnt[IDX_W-1:0]] : '0;
        mem_req_wmask  = mem_req_we ? '1 : '0;
        vrf_we         = (state == WB);
        vrf_waddr      = vrf_we ? vreg_q : '0;
        vrf_wdata      = vrf_we ? beat_buf : '0;
        done           = (state == WB) || (state == FINISH) || (state == ERR);
        err_misaligned = (state == ERR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_cnt  <= '0;
            resp_cnt   <= '0;
            is_store_q <= 1'b0;
            base_q     <= '0;
            vreg_q     <= '0;
        end else if (accept) begin
            issue_cnt  <= '0;
            resp_cnt   <= '0;
            is_store_q <= req_is_store;
            base_q     <= req_base;
            vreg_q     <= req_vreg;
        end else begin
            if (issue_fire) issue_cnt <= issue_cnt + 1'b1;
            if (resp_en)    resp_cnt  <= resp_cnt + 1'b1;
        end
    end
endmodule
